// File: rtl/alu_iter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : alu_iter                                                   |
// | Function : Iterative ADD/SUB/AND/XOR ALU, CHUNK bits per cycle, with  |
// |            zero/sign/overflow flags. Optional ALU_ITER_CC_REG_EN adds |
// |            a registered condition-code port cc = {zf,sf,of}.          |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module alu_iter #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zf,
    output logic             sf,
`ifdef ALU_ITER_CC_REG_EN
    output logic [2:0]       cc,
`endif
    output logic             of
);

    localparam int         c_N  = WIDTH / CHUNK;
    localparam int         c_CW = (c_N > 1) ? $clog2(c_N) : 1;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_SUB = 2'b01;
    localparam logic [1:0] c_OP_AND = 2'b10;

    generate
        if ((WIDTH == 0) || (CHUNK == 0) || (WIDTH % CHUNK != 0)) begin : g_param_check
            $error("alu_iter: WIDTH must be a nonzero multiple of CHUNK");
        end
    endgenerate

    logic [1:0]       r_state, w_state_next;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a, r_b, r_result;
    logic [c_CW-1:0]  r_cnt;
    logic             r_carry, r_zf, r_sf, r_of;

    logic [CHUNK-1:0] w_a_sl, w_b_sl, w_b_eff, w_slice;
    logic [CHUNK:0]   w_sum;
    logic [WIDTH-1:0] w_res_next;
    logic             w_last, w_of, w_accept, w_handshake;

    assign in_ready    = (r_state == c_ST_IDLE);
    assign out_valid   = (r_state == c_ST_DONE);
    assign w_accept    = in_valid && in_ready;
    assign w_handshake = out_valid && out_ready;
    assign w_last      = (r_cnt == c_CW'(c_N - 1));

    // Slice datapath: select slice k of the latched operands and merge the
    // computed slice into the running result.
    always_comb begin
        w_a_sl = '0;
        w_b_sl = '0;
        for (int i = 0; i < c_N; i++) begin
            if (r_cnt == c_CW'(i)) begin
                w_a_sl = r_a[i*CHUNK +: CHUNK];
                w_b_sl = r_b[i*CHUNK +: CHUNK];
            end
        end
        w_b_eff = (r_op == c_OP_SUB) ? ~w_b_sl : w_b_sl;
        w_sum   = {1'b0, w_a_sl} + {1'b0, w_b_eff} + {{CHUNK{1'b0}}, r_carry};
        case (r_op)
            c_OP_ADD, c_OP_SUB: w_slice = w_sum[CHUNK-1:0];
            c_OP_AND:           w_slice = w_a_sl & w_b_sl;
            default:            w_slice = w_a_sl ^ w_b_sl;
        endcase
        w_res_next = r_result;
        for (int i = 0; i < c_N; i++) begin
            if (r_cnt == c_CW'(i)) begin
                w_res_next[i*CHUNK +: CHUNK] = w_slice;
            end
        end
        case (r_op)
            c_OP_ADD: w_of = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_res_next[WIDTH-1] != r_a[WIDTH-1]);
            c_OP_SUB: w_of = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_res_next[WIDTH-1] != r_a[WIDTH-1]);
            default:  w_of = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept)    w_state_next = c_ST_CALC;
            c_ST_CALC: if (w_last)      w_state_next = c_ST_DONE;
            c_ST_DONE: if (w_handshake) w_state_next = c_ST_IDLE;
            default:                    w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= c_ST_IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_zf     <= 1'b0;
            r_sf     <= 1'b0;
            r_of     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op    <= op;
                r_a     <= a;
                r_b     <= b;
                r_cnt   <= '0;
                r_carry <= (op == c_OP_SUB);
            end else if (r_state == c_ST_CALC) begin
                r_result <= w_res_next;
                r_carry  <= w_sum[CHUNK];
                r_cnt    <= r_cnt + c_CW'(1);
                // Flags settle together with the final slice so they are valid on DONE entry.
                if (w_last) begin
                    r_zf <= (w_res_next == '0);
                    r_sf <= w_res_next[WIDTH-1];
                    r_of <= w_of;
                end
            end
        end
    end

    assign result = r_result;
    assign zf     = r_zf;
    assign sf     = r_sf;
    assign of     = r_of;

`ifdef ALU_ITER_CC_REG_EN
    logic [2:0] r_cc;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cc <= 3'b100;
        end else if (w_handshake) begin
            r_cc <= {r_zf, r_sf, r_of};
        end
    end
    assign cc = r_cc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_iter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_alu_iter                                                |
// | Function : Self-checking bench for alu_iter (directed + random).      |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module tb_alu_iter;

    localparam int WIDTH = 64;
    localparam int CHUNK = 16;
    localparam int N     = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       op = 2'b00;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] result;
    logic             zf, sf, of;
`ifdef ALU_ITER_CC_REG_EN
    logic [2:0]       cc;
`endif

    int total = 0;
    int bad   = 0;

    alu_iter #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zf        (zf),
        .sf        (sf),
`ifdef ALU_ITER_CC_REG_EN
        .cc        (cc),
`endif
        .of        (of)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: {result, zf, sf, of} from plain two's-complement arithmetic.
    function automatic logic [WIDTH+2:0] ref_op(input logic [1:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        logic             v;
        v = 1'b0;
        case (o)
            2'b00: begin r = x + y; v = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]); end
            2'b01: begin r = x - y; v = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]); end
            2'b10: r = x & y;
            default: r = x ^ y;
        endcase
        return {r, (r == '0), r[WIDTH-1], v};
    endfunction

    // Transaction-level model: busy for N cycles after accept, then holds result until taken.
    logic             m_live = 1'b0;
    logic             m_calc = 1'b0;
    logic             m_done = 1'b0;
    int               m_left = 0;
    logic [WIDTH-1:0] m_res = '0;
    logic [2:0]       m_f = '0;
    logic [WIDTH+2:0] m_pend = '0;
    logic [2:0]       m_cc = 3'b100;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_live <= 1'b1;
            m_calc <= 1'b0;
            m_done <= 1'b0;
            m_res  <= '0;
            m_f    <= '0;
            m_cc   <= 3'b100;
        end else if (m_calc) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_calc <= 1'b0;
                m_done <= 1'b1;
                m_res  <= m_pend[WIDTH+2:3];
                m_f    <= m_pend[2:0];
            end
        end else if (m_done) begin
            if (out_ready) begin
                m_done <= 1'b0;
                m_cc   <= m_f;
            end
        end else if (in_valid) begin
            m_pend <= ref_op(op, a, b);
            m_calc <= 1'b1;
            m_left <= N;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("in_ready", WIDTH'(in_ready), WIDTH'(!m_calc && !m_done));
            chk("out_valid", WIDTH'(out_valid), WIDTH'(m_done));
            if (!m_calc) begin
                chk("result", result, m_res);
                chk("flags", WIDTH'({zf, sf, of}), WIDTH'(m_f));
            end
`ifdef ALU_ITER_CC_REG_EN
            chk("cc", WIDTH'(cc), WIDTH'(m_cc));
`endif
        end
    end

    // Directed transaction with literal expectations; inputs scrambled after accept.
    task automatic run_op(input logic [1:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic [WIDTH-1:0] er, input logic [2:0] ef, input int hold);
        int lat;
        chk("idle_ready", WIDTH'(in_ready), WIDTH'(1));
        in_valid = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; op = ~o; a = {$urandom, $urandom}; b = {$urandom, $urandom};
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk("latency", WIDTH'(lat), WIDTH'(N));
        chk("lit_result", result, er);
        chk("lit_flags", WIDTH'({zf, sf, of}), WIDTH'(ef));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", WIDTH'(out_valid), WIDTH'(1));
            chk("hold_ready", WIDTH'(in_ready), WIDTH'(0));
            chk("hold_result", result, er);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_valid", WIDTH'(out_valid), WIDTH'(0));
`ifdef ALU_ITER_CC_REG_EN
        chk("lit_cc", WIDTH'(cc), WIDTH'(ef));
`endif
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_result", result, '0);
        chk("rst_valid", WIDTH'(out_valid), WIDTH'(0));
`ifdef ALU_ITER_CC_REG_EN
        chk("rst_cc", WIDTH'(cc), WIDTH'(3'b100));
`endif
        rst_n = 1'b1;

        run_op(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 3'b011, 0);
        run_op(2'b00, 64'h0000_0000_0000_FFFF, 64'h1, 64'h0000_0000_0001_0000, 3'b000, 0);
        run_op(2'b01, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 3'b100, 1);
        run_op(2'b01, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'b011, 0);
        run_op(2'b01, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 3'b001, 0);
        run_op(2'b10, 64'h5, 64'hE, 64'h4, 3'b000, 3);
        run_op(2'b11, 64'h5, 64'hE, 64'hB, 3'b000, 3);
        run_op(2'b01, 64'h5, 64'd14, 64'hFFFF_FFFF_FFFF_FFF7, 3'b010, 2);

        // Reset in the middle of a computation.
        in_valid = 1'b1; op = 2'b00; a = 64'h1234; b = 64'h1111;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_valid", WIDTH'(out_valid), WIDTH'(0));
        chk("abort_result", result, '0);
        chk("abort_flags", WIDTH'({zf, sf, of}), WIDTH'(0));
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_ready", WIDTH'(in_ready), WIDTH'(1));
        run_op(2'b00, 64'h1234, 64'h1111, 64'h2345, 3'b000, 0);

        // Random traffic, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            op        = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: begin a = {1'b0, {(WIDTH-1){1'b1}}}; b = 64'($urandom_range(0, 2)); end
                1: begin a = 64'($urandom_range(0, 3)) << 62; b = {$urandom, $urandom}; end
                default: begin a = {$urandom, $urandom}; b = {$urandom, $urandom}; end
            endcase
            rst_n = ($urandom_range(0, 199) != 0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2 * N + 2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 16, bits processed per compute cycle.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operation request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port op  input  2  operation select: 00 ADD, 01 SUB, 10 AND, 11 XOR.
REQ-008 SHALL have port a  input  WIDTH  first operand, two's complement.
REQ-009 SHALL have port b  input  WIDTH  second operand, two's complement.
REQ-010 SHALL have port out_valid  output  1  result and flags valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  WIDTH  ADD a+b, SUB a-b, AND a&b, XOR a^b.
REQ-013 SHALL have ports zf, sf, of  output  1 each  zero, sign, signed-overflow flags of result.

Function
REQ-014 SHALL require WIDTH to be a nonzero multiple of CHUNK; N = WIDTH/CHUNK compute cycles.
REQ-015 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE; in_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on a rising edge with in_valid && in_ready, latching op, a, b, and clearing chunk counter to 0.
REQ-017 SHALL ignore a, b, op changes after acceptance until the next accept.
REQ-018 SHALL, in CALC, compute one CHUNK slice per cycle, LSB slice first, into result bits [k*CHUNK +: CHUNK] for counter value k.
REQ-019 SHALL propagate a 1-bit carry register between slices; carry-in to slice 0 is 0 for ADD, 1 for SUB; SUB uses ~b.
REQ-020 SHALL transition CALC -> DONE on the edge completing slice N-1; out_valid rises exactly N cycles after the accept edge.
REQ-021 SHALL compute zf = (result == 0), sf = result[WIDTH-1], in DONE.
REQ-022 SHALL compute of: ADD, a and b same sign and result sign differs from a; SUB, a and b signs differ and result sign differs from a; AND/XOR, 0.
REQ-023 SHALL hold result, zf, sf, of, out_valid stable in DONE while out_ready = 0.
REQ-024 SHALL return DONE -> IDLE on out_valid && out_ready; out_valid low next cycle; no new accept in that same cycle.
REQ-025 SHALL keep result and flags at last values in IDLE; only out_valid qualifies them.

Reset
REQ-026 SHALL, on rising edge with rst_n = 0, enter IDLE, clear counter, carry, result, zf, sf, of to 0, out_valid to 0, regardless of state.
REQ-027 SHALL abort any CALC or DONE operation on reset with no output handshake; in_ready = 1 the cycle after rst_n returns high.

Configuration
REQ-028 SHALL, with macro ALU_ITER_CC_REG_EN defined, add port cc  output  3  registered {zf,sf,of}, reset to 3'b100, updated only on out_valid && out_ready.
REQ-029 SHALL, without ALU_ITER_CC_REG_EN, omit port cc and its register; all other behaviour identical.

Verification (WIDTH=64, CHUNK=16, N=4)
REQ-030 ADD a=0x7FFFFFFFFFFFFFFF, b=1 -> result 0x8000000000000000, sf=1, of=1, zf=0, out_valid 4 cycles after accept.
REQ-031 ADD a=0x000000000000FFFF, b=1 -> result 0x0000000000010000 (inter-slice carry); SUB a=b=0x7FFFFFFFFFFFFFFF -> result 0, zf=1, of=0.
REQ-032 SUB a=0x7FFFFFFFFFFFFFFF, b=0x8000000000000000 -> result 0xFFFFFFFFFFFFFFFF, sf=1, of=1; SUB a=0x8000000000000000, b=0x7FFFFFFFFFFFFFFF -> result 1, of=1.
REQ-033 AND/XOR a=0x5, b=0xE -> 0x4 and 0xB, of=0; out_ready held 0 for 3 cycles -> outputs stable, in_ready=0.
REQ-034 rst_n=0 during CALC cycle 2 -> next cycle out_valid=0, result=0, flags=0; in_ready=1 after release; fresh ADD completes normally.
REQ-035 With ALU_ITER_CC_REG_EN: after reset cc=100; SUB a=5, b=14 -> result 0xFFFFFFFFFFFFFFF7, cc=010 after handshake, unchanged while out_ready=0.
